// File: rtl/bcd_stream_mod_checker_pkg.sv
// Shared types, constants and the modular reduction helper
// for the digit-serial BCD divisibility checker.
package bcd_mod_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;
    localparam int RED_W     = 12;
    localparam int MAX_K     = 15;

    // Reduce value (< 16*divisor) modulo divisor by comparing
    // against k*divisor, largest multiple first.
    function automatic logic [7:0] mod_reduce(
        input logic [RED_W-1:0] value,
        input logic [7:0]       divisor
    );
        logic [RED_W-1:0] res;
        logic [RED_W-1:0] mult;
        logic             hit;
        res = value;
        hit = 1'b0;
        for (int k = MAX_K; k >= 0; k--) begin
            mult = RED_W'(k) * {4'b0, divisor};
            if (!hit && value >= mult) begin
                res = value - mult;
                hit = 1'b1;
            end
        end
        return res[7:0];
    endfunction

endpackage

// File: rtl/bcd_stream_mod_checker_if.sv
// Digit stream in / result stream out bundle.
// master: digit source + result sink; slave: the checker.
interface bcd_stream_mod_checker_if #(
    parameter int RW = 4,
    parameter int CW = 5
);
    logic          s_valid;
    logic          s_ready;
    logic [3:0]    s_digit;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic          m_divisible;
    logic [RW-1:0] m_remainder;
    logic [CW-1:0] m_count;
    logic          m_error;
    logic          m_overflow;

    modport master (
        output s_valid, s_digit, s_last, m_ready,
        input  s_ready, m_valid, m_divisible,
        input  m_remainder, m_count, m_error, m_overflow
    );

    modport slave (
        input  s_valid, s_digit, s_last, m_ready,
        output s_ready, m_valid, m_divisible,
        output m_remainder, m_count, m_error, m_overflow
    );
endinterface

// File: rtl/bcd_mod_step.sv
// One-digit remainder step: rem_out = (rem_in*10 + digit) mod DIVISOR.
// Ports: rem_in[RW], digit[4] in; rem_out[RW] out. Purely combinational.
module bcd_mod_step
    import bcd_mod_pkg::*;
#(
    parameter int DIVISOR = 11,
    localparam int RW = $clog2(DIVISOR)
) (
    input  logic [RW-1:0] rem_in,
    input  logic [3:0]    digit,
    output logic [RW-1:0] rem_out
);
    // Max value 10*(DIVISOR-1)+15 always fits in RW+4 bits.
    logic [RW+3:0] sum;

    assign sum = (RW+4)'(rem_in) * (RW+4)'(BCD_RADIX)
               + (RW+4)'(digit);

    assign rem_out = RW'(mod_reduce(RED_W'(sum), 8'(DIVISOR)));

endmodule

// File: rtl/bcd_stream_mod_checker.sv
// Digit-serial BCD divisibility checker, MSD first, one digit per cycle.
// Ports: clk, rst (sync, active-high), bus (slave: s_* digits in, m_* result out).
module bcd_stream_mod_checker
    import bcd_mod_pkg::*;
#(
    parameter int DIVISOR    = 11,
    parameter int MAX_DIGITS = 16
) (
    input logic                      clk,
    input logic                      rst,
    bcd_stream_mod_checker_if.slave  bus
);
    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    state_t        state_q;
    state_t        state_d;
    logic          s_ready_c;
    logic          m_valid_c;
    logic          accept;
    logic          done;
    logic [RW-1:0] rem_q;
    logic [RW-1:0] rem_next;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          ovf_q;

    bcd_mod_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .rem_in  (rem_q),
        .digit   (bus.s_digit),
        .rem_out (rem_next)
    );

    assign accept = bus.s_valid & s_ready_c;
    assign done   = m_valid_c & bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
        unique case (state_q)
            ACCUM: begin
                s_ready_c = 1'b1;
                if (bus.s_valid && bus.s_last)
                    state_d = HOLD;
            end
            HOLD: begin
                m_valid_c = 1'b1;
                if (bus.m_ready)
                    state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            rem_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            rem_q <= rem_next;
            // Out-of-range digits still feed the arithmetic.
            if (bus.s_digit > 4'(BCD_MAX))
                err_q <= 1'b1;
            if (cnt_q == CW'(MAX_DIGITS))
                ovf_q <= 1'b1;
            else
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.m_valid     = m_valid_c;
    assign bus.m_remainder = rem_q;
    assign bus.m_count     = cnt_q;
    assign bus.m_error     = err_q;
    assign bus.m_overflow  = ovf_q;
    // Gated by m_valid so the idle/reset value is 0.
    assign bus.m_divisible = m_valid_c & (rem_q == '0) & ~err_q;

endmodule

// File: tb/tb_bcd_stream_mod_checker.sv
// Directed bench: DIVISOR=11/MAX_DIGITS=16 instance plus a
// DIVISOR=7/MAX_DIGITS=2 instance for digit-count saturation.
module tb_bcd_stream_mod_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_stream_mod_checker_if #(.RW(4), .CW(5)) bus_a ();
    bcd_stream_mod_checker_if #(.RW(3), .CW(2)) bus_b ();

    bcd_stream_mod_checker #(
        .DIVISOR    (11),
        .MAX_DIGITS (16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    bcd_stream_mod_checker #(
        .DIVISOR    (7),
        .MAX_DIGITS (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic a_digit(input logic [3:0] d, input logic last);
        bus_a.s_valid = 1'b1;
        bus_a.s_digit = d;
        bus_a.s_last  = last;
        @(posedge clk);
        #1;
        bus_a.s_valid = 1'b0;
        bus_a.s_last  = 1'b0;
    endtask

    task automatic b_digit(input logic [3:0] d, input logic last);
        bus_b.s_valid = 1'b1;
        bus_b.s_digit = d;
        bus_b.s_last  = last;
        @(posedge clk);
        #1;
        bus_b.s_valid = 1'b0;
        bus_b.s_last  = 1'b0;
    endtask

    // digs holds n BCD nibbles, MSD in the highest used nibble.
    task automatic a_frame(input logic [31:0] digs, input int n);
        for (int i = 0; i < n; i++)
            a_digit(digs[4*(n-1-i) +: 4], i == n - 1);
    endtask

    // Called one cycle after the last digit was accepted.
    task automatic a_result(input string tag, input int rem,
                            input int cnt, input int dv, input int er);
        chk({tag, "_valid"}, 32'(bus_a.m_valid), 1);
        chk({tag, "_rem"}, 32'(bus_a.m_remainder), rem);
        chk({tag, "_cnt"}, 32'(bus_a.m_count), cnt);
        chk({tag, "_div"}, 32'(bus_a.m_divisible), dv);
        chk({tag, "_err"}, 32'(bus_a.m_error), er);
        chk({tag, "_ovf"}, 32'(bus_a.m_overflow), 0);
        bus_a.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.m_ready = 1'b0;
        chk({tag, "_rdy_after"}, 32'(bus_a.s_ready), 1);
        chk({tag, "_val_after"}, 32'(bus_a.m_valid), 0);
    endtask

    task automatic a_idle(input string tag);
        chk({tag, "_s_ready"}, 32'(bus_a.s_ready), 1);
        chk({tag, "_m_valid"}, 32'(bus_a.m_valid), 0);
        chk({tag, "_rem"}, 32'(bus_a.m_remainder), 0);
        chk({tag, "_cnt"}, 32'(bus_a.m_count), 0);
        chk({tag, "_div"}, 32'(bus_a.m_divisible), 0);
        chk({tag, "_err"}, 32'(bus_a.m_error), 0);
        chk({tag, "_ovf"}, 32'(bus_a.m_overflow), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.s_valid = 1'b0;
        bus_a.s_digit = 4'd0;
        bus_a.s_last  = 1'b0;
        bus_a.m_ready = 1'b0;
        bus_b.s_valid = 1'b0;
        bus_b.s_digit = 4'd0;
        bus_b.s_last  = 1'b0;
        bus_b.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_idle("reset");
        rst = 1'b0;

        // 121 = 11*11
        a_frame(32'h121, 3);
        a_result("t1_121", 0, 3, 1, 0);

        // 123 = 11*11 + 2
        a_frame(32'h123, 3);
        a_result("t2_123", 2, 3, 0, 0);

        // 91905 = 11*8355
        a_frame(32'h91905, 5);
        a_result("t2_91905", 0, 5, 1, 0);

        // 1,A,1: 1 -> 20%11=9 -> 91%11=3, error set
        a_frame(32'h1A1, 3);
        a_result("t3_err", 3, 3, 0, 1);

        // 22 = 11*2, error flag must be cleared
        a_frame(32'h22, 2);
        a_result("t3_22", 0, 2, 1, 0);

        // 484 = 11*44, then 5 cycles of backpressure with
        // digits offered that must be ignored
        a_frame(32'h484, 3);
        for (int c = 0; c < 5; c++) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_digit = 4'd7;
            bus_a.s_last  = 1'b1;
            chk("t4_m_valid", 32'(bus_a.m_valid), 1);
            chk("t4_s_ready", 32'(bus_a.s_ready), 0);
            chk("t4_rem", 32'(bus_a.m_remainder), 0);
            chk("t4_cnt", 32'(bus_a.m_count), 3);
            chk("t4_div", 32'(bus_a.m_divisible), 1);
            @(posedge clk);
            #1;
        end
        bus_a.s_valid = 1'b0;
        bus_a.s_last  = 1'b0;
        bus_a.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.m_ready = 1'b0;
        chk("t4_s_ready_after", 32'(bus_a.s_ready), 1);
        chk("t4_m_valid_after", 32'(bus_a.m_valid), 0);
        chk("t4_cnt_after", 32'(bus_a.m_count), 0);

        // DIVISOR=7, MAX_DIGITS=2: 343 = 7^3, count saturates
        b_digit(4'd3, 1'b0);
        b_digit(4'd4, 1'b0);
        b_digit(4'd3, 1'b1);
        chk("t5_valid", 32'(bus_b.m_valid), 1);
        chk("t5_rem", 32'(bus_b.m_remainder), 0);
        chk("t5_cnt", 32'(bus_b.m_count), 2);
        chk("t5_ovf", 32'(bus_b.m_overflow), 1);
        chk("t5_div", 32'(bus_b.m_divisible), 1);
        chk("t5_err", 32'(bus_b.m_error), 0);
        bus_b.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_b.m_ready = 1'b0;
        chk("t5_ovf_clr", 32'(bus_b.m_overflow), 0);

        // Reset mid-frame: 34 %11 = 1 before reset
        a_digit(4'd3, 1'b0);
        a_digit(4'd4, 1'b0);
        chk("t6_partial_rem", 32'(bus_a.m_remainder), 1);
        chk("t6_partial_cnt", 32'(bus_a.m_count), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_idle("t6_reset");
        a_frame(32'h5, 1);
        a_result("t6_5", 5, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
